// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the modulo-N counter family (up and down variants).
//
//   DEFAULT_MOD  : modulus used when a counter is instantiated without an
//                  explicit MOD (13, matching the original mod-13 counter).
//   cnt_width()  : number of bits needed to hold 0..mod-1, never less than 1.
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int DEFAULT_MOD = 13;

    // $clog2(1) is 0, which would collapse the count to a zero-width vector,
    // so the width is floored at one bit.
    function automatic int cnt_width(input int mod);
        int w;
        w = $clog2(mod);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dff_sync.sv
// -----------------------------------------------------------------------------
// dff_sync
//   Single-bit D flip-flop with synchronous, active-high reset. The reset value
//   is a parameter so a vector of these can power up to an arbitrary constant.
//
//   Parameters:
//     RST_VAL : value loaded into q when rst is high on a rising clk edge
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset
//     d   : next-state input
//     q   : registered output
// -----------------------------------------------------------------------------
module dff_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mod_n_down_counter.sv
// -----------------------------------------------------------------------------
// mod_n_down_counter
//   Parameterised modulo-N down counter. Counts MOD-1 down to 0 and either wraps
//   back to MOD-1 or, in one-shot mode, halts at 0 and raises a sticky done.
//   A synchronous parallel load (with range clamping) and a combinational
//   terminal-count output allow stages to be cascaded directly.
//
//   Parameters:
//     Modulus  : parameter MOD, 2..65536 (default 13)
//     WIDTH    : derived count width, not overridable
//   Ports:
//     clk      : rising-edge clock
//     rst      : synchronous active-high reset (count=MOD-1, done=0)
//     en       : count enable, one decrement per edge while high
//     load     : parallel-load strobe, takes priority over en
//     load_val : value to load; values >= MOD clamp to MOD-1
//     oneshot  : 0 = wrap at zero, 1 = halt at zero
//     count    : registered current count
//     tc       : combinational terminal count, en & (count == 0)
//     done     : registered sticky one-shot completion flag
//     load_err : one-cycle pulse after a load with an out-of-range value
// -----------------------------------------------------------------------------
module mod_n_down_counter
    import counter_pkg::*;
#(
    parameter  int MOD   = DEFAULT_MOD,
    localparam int WIDTH = cnt_width(MOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             load_err
);

    // Largest legal count; also the reset and wrap target.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] count_next;
    logic             done_next;
    logic             load_err_next;
    logic             at_zero;

    assign at_zero = (count == '0);

    // Zero latency with respect to en so a downstream stage can use it as its
    // enable. It also fires while halted at zero in one-shot mode; a consumer
    // wanting a single borrow must qualify it with ~done.
    assign tc = en & at_zero;

    // Next-state logic, priority load > en > hold (reset lives in the
    // registers). load_err defaults low so it can only ever be a single-cycle
    // pulse. The range compare is at WIDTH bits and is trivially false when the
    // modulus is a power of two, which is exactly when every load_val is legal.
    always_comb begin
        count_next    = count;
        done_next     = done;
        load_err_next = 1'b0;
        if (load) begin
            done_next = 1'b0;
            if (load_val > MAX_VAL) begin
                count_next    = MAX_VAL;
                load_err_next = 1'b1;
            end else begin
                count_next = load_val;
            end
        end else if (en) begin
            if (!at_zero) begin
                count_next = count - WIDTH'(1);
            end else if (oneshot) begin
                count_next = '0;
                done_next  = 1'b1;
            end else begin
                count_next = MAX_VAL;
            end
        end
    end

    // The count register is a row of single-bit flops whose individual reset
    // values are taken from the bits of MOD-1, so reset lands on MOD-1 even for
    // a non-power-of-two modulus.
    for (genvar i = 0; i < WIDTH; i++) begin : g_count_bit
        dff_sync #(
            .RST_VAL (MAX_VAL[i])
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .d   (count_next[i]),
            .q   (count[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            done     <= done_next;
            load_err <= load_err_next;
        end
    end

endmodule

// File: tb/tb_mod_n_down_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_n_down_counter
//   Self-checking bench for mod_n_down_counter (MOD = 13) plus a two-stage
//   cascade (stage A tc driving stage B en). Expected values are pushed onto a
//   scoreboard queue when each step is driven and popped after the clock edge.
// -----------------------------------------------------------------------------
module tb_mod_n_down_counter;

    localparam int MOD = 13;
    localparam int W   = 4;

    typedef struct packed {
        logic [W-1:0] count;
        logic         tc;
        logic         done;
        logic         load_err;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a_count;
        logic [W-1:0] b_count;
    } casc_exp_t;

    logic         clk = 1'b0;
    logic         rst, en, load, oneshot;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         tc, done, load_err;

    logic         casc_rst, casc_en;
    logic [W-1:0] a_count, b_count;
    logic         a_tc, b_tc, a_done, b_done, a_err, b_err;

    exp_t      exp_q[$];
    string     tag_q[$];
    casc_exp_t casc_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_n_down_counter #(.MOD(MOD)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .oneshot  (oneshot),
        .count    (count),
        .tc       (tc),
        .done     (done),
        .load_err (load_err)
    );

    mod_n_down_counter #(.MOD(MOD)) u_stage_a (
        .clk      (clk),
        .rst      (casc_rst),
        .en       (casc_en),
        .load     (1'b0),
        .load_val (4'd0),
        .oneshot  (1'b0),
        .count    (a_count),
        .tc       (a_tc),
        .done     (a_done),
        .load_err (a_err)
    );

    mod_n_down_counter #(.MOD(MOD)) u_stage_b (
        .clk      (clk),
        .rst      (casc_rst),
        .en       (a_tc),
        .load     (1'b0),
        .load_val (4'd0),
        .oneshot  (1'b0),
        .count    (b_count),
        .tc       (b_tc),
        .done     (b_done),
        .load_err (b_err)
    );

    // Pops the oldest expectation and compares every output field.
    task automatic checkOutput();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (count === e.count) else begin
            errors++;
            $error("[TB] FAIL %s.count observed=%0d expected=%0d", t, count, e.count);
        end
        checks++;
        assert (tc === e.tc) else begin
            errors++;
            $error("[TB] FAIL %s.tc observed=%0b expected=%0b", t, tc, e.tc);
        end
        checks++;
        assert (done === e.done) else begin
            errors++;
            $error("[TB] FAIL %s.done observed=%0b expected=%0b", t, done, e.done);
        end
        checks++;
        assert (load_err === e.load_err) else begin
            errors++;
            $error("[TB] FAIL %s.load_err observed=%0b expected=%0b", t, load_err, e.load_err);
        end
    endtask

    // Drives one step, records the expected post-edge state, advances one
    // edge and checks. Expected tc follows from the held en and expected count.
    task automatic applyStimulus(input string tag, input logic r, input logic l,
                                 input int lv, input logic e, input logic os,
                                 input int exp_count, input logic exp_done,
                                 input logic exp_err);
        exp_t x;
        rst      = r;
        load     = l;
        load_val = W'(lv);
        en       = e;
        oneshot  = os;
        x.count    = W'(exp_count);
        x.tc       = e && (exp_count == 0);
        x.done     = exp_done;
        x.load_err = exp_err;
        exp_q.push_back(x);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        casc_exp_t ce;
        casc_exp_t co;

        rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; oneshot = 1'b0;
        casc_rst = 1'b1; casc_en = 1'b0;

        // Reset state.
        applyStimulus("reset", 1, 0, 0, 0, 0, 12, 0, 0);

        // Free-running wrap: 11..0 then 12, 11.
        for (int i = 1; i <= 14; i++)
            applyStimulus("wrap", 0, 0, 0, 1, 0, (12 - (i % 13) + 13) % 13, 0, 0);

        // In-range load then count down.
        applyStimulus("load5", 0, 1, 5, 0, 0, 5, 0, 0);
        for (int i = 1; i <= 3; i++)
            applyStimulus("after_load5", 0, 0, 0, 1, 0, 5 - i, 0, 0);

        // Out-of-range loads clamp and pulse load_err for one cycle.
        applyStimulus("load14", 0, 1, 14, 0, 0, 12, 0, 1);
        applyStimulus("load14_hold", 0, 0, 0, 0, 0, 12, 0, 0);
        applyStimulus("load15", 0, 1, 15, 0, 0, 12, 0, 1);
        applyStimulus("load15_hold", 0, 0, 0, 0, 0, 12, 0, 0);

        // One-shot: 3,2,1,0 then halt with done sticky.
        applyStimulus("os_load3", 0, 1, 3, 0, 1, 3, 0, 0);
        applyStimulus("os_cnt", 0, 0, 0, 1, 1, 2, 0, 0);
        applyStimulus("os_cnt", 0, 0, 0, 1, 1, 1, 0, 0);
        applyStimulus("os_zero", 0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus("os_halt", 0, 0, 0, 1, 1, 0, 1, 0);
        applyStimulus("os_halt", 0, 0, 0, 1, 1, 0, 1, 0);
        applyStimulus("os_halt", 0, 0, 0, 1, 1, 0, 1, 0);
        // Dropping oneshot and en leaves done set and tc low at zero.
        applyStimulus("os_sticky", 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus("os_clear", 0, 1, 7, 0, 0, 7, 0, 0);

        // Load wins over en on the same edge.
        applyStimulus("load_en", 0, 1, 9, 1, 0, 9, 0, 0);

        // Reset mid-count at 4.
        for (int i = 1; i <= 5; i++)
            applyStimulus("pre_rst", 0, 0, 0, 1, 0, 9 - i, 0, 0);
        applyStimulus("rst_mid", 1, 0, 0, 1, 0, 12, 0, 0);

        // Reset beats load, and clears a set done.
        applyStimulus("os_load0", 0, 1, 0, 0, 1, 0, 0, 0);
        applyStimulus("os_done", 0, 0, 0, 1, 1, 0, 1, 0);
        applyStimulus("rst_load", 1, 1, 3, 1, 1, 12, 0, 0);

        // Cascade: B steps once per A wrap, both back at 12 after 169 edges.
        @(posedge clk);
        #1;
        casc_rst = 1'b0;
        casc_en  = 1'b1;
        for (int k = 1; k <= 169; k++) begin
            ce.a_count = W'((12 - (k % 13) + 13) % 13);
            ce.b_count = W'((12 - (k / 13) + 13) % 13);
            casc_q.push_back(ce);
            @(posedge clk);
            #1;
            co = casc_q.pop_front();
            checks++;
            assert (a_count === co.a_count) else begin
                errors++;
                $error("[TB] FAIL cascade_a k=%0d observed=%0d expected=%0d", k, a_count, co.a_count);
            end
            checks++;
            assert (b_count === co.b_count) else begin
                errors++;
                $error("[TB] FAIL cascade_b k=%0d observed=%0d expected=%0d", k, b_count, co.b_count);
            end
        end
        casc_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
